// File: rtl/complex_mac_pkg.sv
// Shared width arithmetic for the complex multiply-accumulate block.
package complex_mac_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

    // One guard bit covers the sum of two full-range products.
    function automatic int mult_width(input int a_width, input int b_width);
        return a_width + b_width + 32'sd1;
    endfunction

    function automatic int acc_width(input int a_width, input int b_width, input int acc_len);
        return mult_width(a_width, b_width) + clog2(acc_len);
    endfunction

    function automatic int beat_width(input int acc_len);
        return (clog2(acc_len) > 32'sd0) ? clog2(acc_len) : 32'sd1;
    endfunction

endpackage

// File: rtl/complex_mult_pipe.sv
// Two-stage registered complex multiplier with optional conjugate of B and a
// common stall enable.
module complex_mult_pipe
    import complex_mac_pkg::*;
#(
    parameter  int DINA_WIDTH = 8,
    parameter  int DINB_WIDTH = 8,
    localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic signed [DINA_WIDTH-1:0] i_a_i,
    input  logic signed [DINA_WIDTH-1:0] i_a_q,
    input  logic signed [DINB_WIDTH-1:0] i_b_i,
    input  logic signed [DINB_WIDTH-1:0] i_b_q,
    input  logic                         i_conj,
    output logic                         o_valid,
    output logic signed [MULT_WIDTH-1:0] o_p_i,
    output logic signed [MULT_WIDTH-1:0] o_p_q
);

    logic signed [MULT_WIDTH-1:0] w_a_i_ext;
    logic signed [MULT_WIDTH-1:0] w_a_q_ext;
    logic signed [MULT_WIDTH-1:0] w_b_i_ext;
    logic signed [MULT_WIDTH-1:0] w_b_q_ext;
    logic signed [MULT_WIDTH-1:0] w_b_q_eff;

    logic                         r_valid1;
    logic signed [MULT_WIDTH-1:0] r_pp_ii;
    logic signed [MULT_WIDTH-1:0] r_pp_qq;
    logic signed [MULT_WIDTH-1:0] r_pp_iq;
    logic signed [MULT_WIDTH-1:0] r_pp_qi;
    logic                         r_valid2;
    logic signed [MULT_WIDTH-1:0] r_p_i;
    logic signed [MULT_WIDTH-1:0] r_p_q;

    // Widening before the multiply keeps -b_q representable for the most negative input.
    assign w_a_i_ext = MULT_WIDTH'(i_a_i);
    assign w_a_q_ext = MULT_WIDTH'(i_a_q);
    assign w_b_i_ext = MULT_WIDTH'(i_b_i);
    assign w_b_q_ext = MULT_WIDTH'(i_b_q);
    assign w_b_q_eff = i_conj ? -w_b_q_ext : w_b_q_ext;

    // Partial products then their complex combination, both frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid1 <= 1'b0;
            r_pp_ii  <= {MULT_WIDTH{1'b0}};
            r_pp_qq  <= {MULT_WIDTH{1'b0}};
            r_pp_iq  <= {MULT_WIDTH{1'b0}};
            r_pp_qi  <= {MULT_WIDTH{1'b0}};
            r_valid2 <= 1'b0;
            r_p_i    <= {MULT_WIDTH{1'b0}};
            r_p_q    <= {MULT_WIDTH{1'b0}};
        end else if (i_en) begin
            r_valid1 <= i_valid;
            r_pp_ii  <= w_a_i_ext * w_b_i_ext;
            r_pp_qq  <= w_a_q_ext * w_b_q_eff;
            r_pp_iq  <= w_a_i_ext * w_b_q_eff;
            r_pp_qi  <= w_a_q_ext * w_b_i_ext;
            r_valid2 <= r_valid1;
            r_p_i    <= r_pp_ii - r_pp_qq;
            r_p_q    <= r_pp_iq + r_pp_qi;
        end
    end

    assign o_valid = r_valid2;
    assign o_p_i   = r_p_i;
    assign o_p_q   = r_p_q;

endmodule

// File: rtl/complex_mac.sv
// Complex multiply-accumulate: sums ACC_LEN products per result, with a
// valid/ready stream on both sides and a whole-pipeline stall.
module complex_mac
    import complex_mac_pkg::*;
#(
    parameter  int DINA_WIDTH = 8,
    parameter  int DINB_WIDTH = 8,
    parameter  int ACC_LEN    = 1,
    localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH),
    localparam int ACC_WIDTH  = acc_width(DINA_WIDTH, DINB_WIDTH, ACC_LEN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DINA_WIDTH-1:0] dina_i,
    input  logic signed [DINA_WIDTH-1:0] dina_q,
    input  logic signed [DINB_WIDTH-1:0] dinb_i,
    input  logic signed [DINB_WIDTH-1:0] dinb_q,
    input  logic                         conj_b,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic signed [ACC_WIDTH-1:0]  acc_q
);

    localparam int                    BEAT_WIDTH = beat_width(ACC_LEN);
    localparam logic [BEAT_WIDTH-1:0] BEAT_LAST  = BEAT_WIDTH'(ACC_LEN - 1);

    logic                         w_en;
    logic                         w_valid2;
    logic signed [MULT_WIDTH-1:0] w_p_i;
    logic signed [MULT_WIDTH-1:0] w_p_q;
    logic signed [ACC_WIDTH-1:0]  w_p_i_ext;
    logic signed [ACC_WIDTH-1:0]  w_p_q_ext;

    logic [BEAT_WIDTH-1:0]        r_beat;
    logic                         r_m_valid;
    logic signed [ACC_WIDTH-1:0]  r_acc_i;
    logic signed [ACC_WIDTH-1:0]  r_acc_q;

    // The only stall source is an unaccepted result; everything advances together otherwise.
    assign w_en    = !(r_m_valid && !m_ready);
    assign s_ready = w_en;

    complex_mult_pipe #(
        .DINA_WIDTH (DINA_WIDTH),
        .DINB_WIDTH (DINB_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_valid (s_valid),
        .i_a_i   (dina_i),
        .i_a_q   (dina_q),
        .i_b_i   (dinb_i),
        .i_b_q   (dinb_q),
        .i_conj  (conj_b),
        .o_valid (w_valid2),
        .o_p_i   (w_p_i),
        .o_p_q   (w_p_q)
    );

    assign w_p_i_ext = ACC_WIDTH'(w_p_i);
    assign w_p_q_ext = ACC_WIDTH'(w_p_q);

    // Accumulator and beat counter; beat 0 loads so no stale sum leaks into a new group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= {BEAT_WIDTH{1'b0}};
            r_m_valid <= 1'b0;
            r_acc_i   <= {ACC_WIDTH{1'b0}};
            r_acc_q   <= {ACC_WIDTH{1'b0}};
        end else if (w_en) begin
            if (w_valid2) begin
                if (r_beat == {BEAT_WIDTH{1'b0}}) begin
                    r_acc_i <= w_p_i_ext;
                    r_acc_q <= w_p_q_ext;
                end else begin
                    r_acc_i <= r_acc_i + w_p_i_ext;
                    r_acc_q <= r_acc_q + w_p_q_ext;
                end
                if (r_beat == BEAT_LAST) begin
                    r_beat    <= {BEAT_WIDTH{1'b0}};
                    r_m_valid <= 1'b1;
                end else begin
                    r_beat    <= r_beat + BEAT_WIDTH'(1'b1);
                    r_m_valid <= 1'b0;
                end
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign acc_i   = r_acc_i;
    assign acc_q   = r_acc_q;

endmodule

// File: tb/tb_complex_mac.sv
// Self-checking bench: one ACC_LEN=1 and one ACC_LEN=4 instance, directed
// vectors plus randomized streams checked against an integer scoreboard.
module tb_complex_mac;

    localparam int W1 = 17;
    localparam int W4 = 19;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 s_valid1, s_ready1, conj_b1, m_valid1, m_ready1;
    logic signed [7:0]    dina_i1, dina_q1, dinb_i1, dinb_q1;
    logic signed [W1-1:0] acc1_i, acc1_q;

    logic                 s_valid4, s_ready4, conj_b4, m_valid4, m_ready4;
    logic signed [7:0]    dina_i4, dina_q4, dinb_i4, dinb_q4;
    logic signed [W4-1:0] acc4_i, acc4_q;

    complex_mac #(.DINA_WIDTH(8), .DINB_WIDTH(8), .ACC_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_ready(s_ready1),
        .dina_i(dina_i1), .dina_q(dina_q1), .dinb_i(dinb_i1), .dinb_q(dinb_q1),
        .conj_b(conj_b1), .m_valid(m_valid1), .m_ready(m_ready1),
        .acc_i(acc1_i), .acc_q(acc1_q)
    );

    complex_mac #(.DINA_WIDTH(8), .DINB_WIDTH(8), .ACC_LEN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4),
        .dina_i(dina_i4), .dina_q(dina_q4), .dinb_i(dinb_i4), .dinb_q(dinb_q4),
        .conj_b(conj_b4), .m_valid(m_valid4), .m_ready(m_ready4),
        .acc_i(acc4_i), .acc_q(acc4_q)
    );

    int checks = 0;
    int errors = 0;

    int q1i[$], q1q[$], q4i[$], q4q[$];
    int sum4_i, sum4_q, cnt4;
    bit done;

    typedef struct {
        int ai, aq, bi, bq;
        bit c;
        int ei, eq;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void cmul(input int ai, aq, bi, bq, input bit c, output int pi, output int pq);
        int bqe;
        bqe = c ? -bq : bq;
        pi  = ai * bi - aq * bqe;
        pq  = ai * bqe + aq * bi;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    // Scoreboard: transfers seen at the negedge take effect on the next rising edge.
    always @(negedge clk) begin
        int pi, pq;
        if (!rst_n) begin
            q1i.delete(); q1q.delete(); q4i.delete(); q4q.delete();
            sum4_i = 0; sum4_q = 0; cnt4 = 0;
        end else begin
            chk("s_ready1_rule", int'(s_ready1), int'(!(m_valid1 && !m_ready1)));
            chk("s_ready4_rule", int'(s_ready4), int'(!(m_valid4 && !m_ready4)));
            if (m_valid1) begin
                chk("dut1_has_pending", int'(q1i.size() > 0), 1);
                if (q1i.size() > 0) begin
                    chk("dut1_acc_i", int'(acc1_i), q1i[0]);
                    chk("dut1_acc_q", int'(acc1_q), q1q[0]);
                    if (m_ready1) begin
                        void'(q1i.pop_front());
                        void'(q1q.pop_front());
                    end
                end
            end
            if (m_valid4) begin
                chk("dut4_has_pending", int'(q4i.size() > 0), 1);
                if (q4i.size() > 0) begin
                    chk("dut4_acc_i", int'(acc4_i), q4i[0]);
                    chk("dut4_acc_q", int'(acc4_q), q4q[0]);
                    if (m_ready4) begin
                        void'(q4i.pop_front());
                        void'(q4q.pop_front());
                    end
                end
            end
            if (s_valid1 && s_ready1) begin
                cmul(int'(dina_i1), int'(dina_q1), int'(dinb_i1), int'(dinb_q1), conj_b1, pi, pq);
                q1i.push_back(pi);
                q1q.push_back(pq);
            end
            if (s_valid4 && s_ready4) begin
                cmul(int'(dina_i4), int'(dina_q4), int'(dinb_i4), int'(dinb_q4), conj_b4, pi, pq);
                sum4_i += pi;
                sum4_q += pq;
                cnt4++;
                if (cnt4 == 4) begin
                    q4i.push_back(sum4_i);
                    q4q.push_back(sum4_q);
                    sum4_i = 0; sum4_q = 0; cnt4 = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send1(input int ai, aq, bi, bq, input bit c);
        int n;
        bit ok;
        dina_i1 = 8'(ai); dina_q1 = 8'(aq); dinb_i1 = 8'(bi); dinb_q1 = 8'(bq);
        conj_b1 = c; s_valid1 = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready1;
            @(posedge clk);
            n++;
        end
        #1;
        s_valid1 = 1'b0;
        chk("send1_accepted", int'(ok), 1);
    endtask

    task automatic send4(input int ai, aq, bi, bq, input bit c);
        int n;
        bit ok;
        dina_i4 = 8'(ai); dina_q4 = 8'(aq); dinb_i4 = 8'(bi); dinb_q4 = 8'(bq);
        conj_b4 = c; s_valid4 = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready4;
            @(posedge clk);
            n++;
        end
        #1;
        s_valid4 = 1'b0;
        chk("send4_accepted", int'(ok), 1);
    endtask

    // Latency counts negedges after the accepting edge until m_valid is seen.
    task automatic wait1(output int lat, output int ri, output int rq);
        lat = 0; ri = 0; rq = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (m_valid1) break;
        end
        chk("wait1_m_valid", int'(m_valid1), 1);
        ri = int'(acc1_i); rq = int'(acc1_q);
        @(posedge clk);
        #1;
    endtask

    task automatic wait4(output int lat, output int ri, output int rq);
        lat = 0; ri = 0; rq = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (m_valid4) break;
        end
        chk("wait4_m_valid", int'(m_valid4), 1);
        ri = int'(acc4_i); rq = int'(acc4_q);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_m_valid1", int'(m_valid1), 0);
        chk("rst_s_ready1", int'(s_ready1), 1);
        chk("rst_acc1_i", int'(acc1_i), 0);
        chk("rst_acc1_q", int'(acc1_q), 0);
        chk("rst_m_valid4", int'(m_valid4), 0);
        chk("rst_s_ready4", int'(s_ready4), 1);
        chk("rst_acc4_i", int'(acc4_i), 0);
        chk("rst_acc4_q", int'(acc4_q), 0);
    endtask

    initial begin
        int lat, ri, rq, lowcnt;

        tbl[0] = '{ai:   3, aq:   4, bi:    5, bq:    6, c: 1'b0, ei:    -9, eq:     38};
        tbl[1] = '{ai:   3, aq:   4, bi:    5, bq:    6, c: 1'b1, ei:    39, eq:      2};
        tbl[2] = '{ai:-128, aq:-128, bi: -128, bq: -128, c: 1'b0, ei:     0, eq:  32768};
        tbl[3] = '{ai:-128, aq:-128, bi: -128, bq: -128, c: 1'b1, ei: 32768, eq:      0};
        tbl[4] = '{ai: 127, aq: 127, bi: -128, bq: -128, c: 1'b0, ei:     0, eq: -32512};
        tbl[5] = '{ai:   0, aq:   1, bi:    0, bq:    1, c: 1'b0, ei:    -1, eq:      0};
        tbl[6] = '{ai:  -1, aq:   0, bi:    5, bq:   -7, c: 1'b1, ei:    -5, eq:     -7};

        rst_n = 1'b0;
        s_valid1 = 1'b0; conj_b1 = 1'b0; m_ready1 = 1'b1;
        dina_i1 = 8'sd0; dina_q1 = 8'sd0; dinb_i1 = 8'sd0; dinb_q1 = 8'sd0;
        s_valid4 = 1'b0; conj_b4 = 1'b0; m_ready4 = 1'b1;
        dina_i4 = 8'sd0; dina_q4 = 8'sd0; dinb_i4 = 8'sd0; dinb_q4 = 8'sd0;
        repeat (3) @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 7; k++) begin
            send1(tbl[k].ai, tbl[k].aq, tbl[k].bi, tbl[k].bq, tbl[k].c);
            wait1(lat, ri, rq);
            chk($sformatf("vec%0d_latency", k), lat, 3);
            chk($sformatf("vec%0d_i", k), ri, tbl[k].ei);
            chk($sformatf("vec%0d_q", k), rq, tbl[k].eq);
        end
        idle(3);

        // Back-to-back stream with a five-cycle output stall.
        lowcnt = 0;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    send1(rnd8(), rnd8(), rnd8(), rnd8(), 1'($urandom_range(1, 0)));
            end
            begin
                idle(8);
                m_ready1 = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!s_ready1) lowcnt++;
                end
                @(posedge clk);
                #1;
                m_ready1 = 1'b1;
            end
        join
        chk("stall_s_ready_low_cycles", lowcnt, 5);
        idle(8);
        chk("stream1_drained", q1i.size(), 0);

        // Group of four with a bubble between the 2nd and 3rd sample.
        send4(1, 1, 1, 1, 1'b0);
        send4(1, 1, 1, 1, 1'b0);
        idle(1);
        send4(1, 1, 1, 1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("grp_no_early_m_valid", int'(m_valid4), 0);
        end
        @(posedge clk);
        #1;
        send4(1, 1, 1, 1, 1'b0);
        wait4(lat, ri, rq);
        chk("grp_latency", lat, 3);
        chk("grp_i", ri, 0);
        chk("grp_q", rq, 8);
        idle(2);

        // Reset in the middle of a group discards the partial sum.
        send4(50, -3, 7, 9, 1'b1);
        send4(-20, 11, 4, -6, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        repeat (4) send4(2, 0, 1, 0, 1'b0);
        wait4(lat, ri, rq);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_i", ri, 8);
        chk("post_rst_q", rq, 0);
        idle(2);

        // Result must hold while downstream refuses it.
        m_ready4 = 1'b0;
        repeat (4) send4(3, 1, 2, -1, 1'b0);
        wait4(lat, ri, rq);
        chk("hold_i", ri, 28);
        chk("hold_q", rq, -4);
        repeat (4) begin
            @(negedge clk);
            chk("hold_m_valid", int'(m_valid4), 1);
            chk("hold_s_ready", int'(s_ready4), 0);
            chk("hold_acc_i", int'(acc4_i), 28);
            chk("hold_acc_q", int'(acc4_q), -4);
        end
        @(posedge clk);
        #1;
        m_ready4 = 1'b1;
        idle(3);
        chk("hold_released", int'(m_valid4), 0);

        // Random traffic with bubbles and random backpressure on both instances.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    if ($urandom_range(3, 0) == 0) idle(1);
                    send1(rnd8(), rnd8(), rnd8(), rnd8(), 1'($urandom_range(1, 0)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready1 = ($urandom_range(3, 0) != 0);
                end
                m_ready1 = 1'b1;
            end
        join
        idle(8);

        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 48; k++) begin
                    if ($urandom_range(3, 0) == 0) idle(1);
                    send4(rnd8(), rnd8(), rnd8(), rnd8(), 1'($urandom_range(1, 0)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready4 = ($urandom_range(2, 0) != 0);
                end
                m_ready4 = 1'b1;
            end
        join
        idle(8);

        chk("final_q1_empty", q1i.size(), 0);
        chk("final_q4_empty", q4i.size(), 0);
        chk("final_partial_group", cnt4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
